prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4, number of consecutive predicted-word matches required to declare lock; legal range 1..255.
REQ-002 Parameter LOSS_CNT, default 3, number of consecutive mismatches while locked that declare loss of lock; legal range 1..255.
REQ-003 clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_i  input  1  data_i carries one word this cycle.
REQ-006 data_i  input  16  received word; a correct stream is successive states of the team's 16-bit LFSR.
REQ-007 clear_i  input  1  synchronous clear of err_cnt_o and loss_cnt_o.
REQ-008 locked_o  output  1  high while the checker is in LOCKED.
REQ-009 err_o  output  1  one-cycle pulse per counted mismatch.
REQ-010 err_cnt_o  output  16  saturating count of mismatches while locked.
REQ-011 loss_cnt_o  output  8  saturating count of lock losses.

Function
REQ-012 Step function, same polynomial as the generator: next[14:0] = cur[15:1]; next[15] = cur[0]^cur[1]^cur[3]^cur[12].
REQ-013 Internal state: FSM {SEARCH, TRACK, LOCKED}, 16-bit expected word exp_q, 8-bit match counter, 8-bit miss counter.
REQ-014 Cycles with valid_i=0 change no state, counter or output except clearing err_o and applying clear_i.
REQ-015 SEARCH, valid, data_i!=0: exp_q <= step(data_i), match counter <= 0, go TRACK; data_i==0 (LFSR lock-up word) ignored.
REQ-016 TRACK, valid, data_i==exp_q: exp_q <= step(exp_q), match counter +1; when the match is the LOCK_CNT-th, go LOCKED and clear miss counter.
REQ-017 TRACK, valid, mismatch, data_i!=0: re-seed, exp_q <= step(data_i), match counter <= 0, stay TRACK.
REQ-018 TRACK, valid, mismatch, data_i==0: go SEARCH.
REQ-019 LOCKED, valid: exp_q <= step(exp_q) regardless of compare (no re-seeding while locked).
REQ-020 LOCKED, valid, match: miss counter <= 0.
REQ-021 LOCKED, valid, mismatch: err_o=1 next cycle, err_cnt_o +1 saturating at 0xFFFF, miss counter +1.
REQ-022 LOCKED, mismatch that is the LOSS_CNT-th consecutive: go SEARCH, loss_cnt_o +1 saturating at 0xFF, miss counter <= 0; that mismatch is still counted in err_cnt_o.
REQ-023 Mismatches in SEARCH/TRACK never assert err_o nor touch err_cnt_o.
REQ-024 All outputs registered; locked_o, err_o, counters reflect a beat on the cycle after that beat's rising edge.
REQ-025 clear_i=1 forces err_cnt_o and loss_cnt_o to 0 that edge, priority over a simultaneous increment; FSM, exp_q, err_o unaffected.
REQ-026 LOCK_CNT=1: first match after seeding locks. LOSS_CNT=1: first locked mismatch drops lock.

Reset
REQ-027 rst_ni low at any time, including mid-lock: FSM=SEARCH, exp_q=0, match/miss counters=0, locked_o=0, err_o=0, err_cnt_o=0, loss_cnt_o=0, held until rst_ni high.
REQ-028 First valid beat evaluated is the first valid_i=1 cycle after rst_ni deasserts.

Verification
REQ-029 Reset, then idle -> locked_o=0, err_o=0, err_cnt_o=0x0000, loss_cnt_o=0x00.
REQ-030 LOCK_CNT=4, valid words 0xCAFE, 0x657F, 0xB2BF, then next two generator states -> locked_o=1 the cycle after the 5th word, err_cnt_o=0.
REQ-031 Locked, one word XOR 0x0001, correct stream resumes -> single err_o pulse, err_cnt_o=1, locked_o stays 1, following words match.
REQ-032 Locked, LOSS_CNT=3, three consecutive corrupted words -> err_cnt_o=3, loss_cnt_o=1, locked_o=0 the cycle after the third; correct stream re-locks after 1+LOCK_CNT words.
REQ-033 SEARCH with 0x0000 words, and locked stream with random valid_i gaps -> zero words ignored, gaps cause no errors or loss.
REQ-034 clear_i asserted on same edge as a locked mismatch -> err_cnt_o=0 next cycle, err_o still pulses; rst_ni pulsed while locked -> all outputs zero immediately.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS checker for the 16-bit LFSR stream: seeds from received data, locks after
// LOCK_CNT consecutive predicted matches, and counts errors and lock losses while locked.
module prbs_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [15:0] data_i,
  input  logic        clear_i,
  output logic        locked_o,
  output logic        err_o,
  output logic [15:0] err_cnt_o,
  output logic [7:0]  loss_cnt_o
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

  function automatic logic [15:0] step(input logic [15:0] cur);
    return {cur[0] ^ cur[1] ^ cur[3] ^ cur[12], cur[15:1]};
  endfunction

  state_e      state_q, state_d;
  logic [15:0] exp_q, exp_d;
  logic [7:0]  match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SEARCH;
      exp_q      <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (valid_i) begin
      unique case (state_q)
        SEARCH: begin
          // The all-zero word is the LFSR lock-up state and can never seed.
          if (data_i != '0) begin
            exp_d   = step(data_i);
            match_d = '0;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (data_i == exp_q) begin
            exp_d   = step(exp_q);
            match_d = match_q + 8'd1;
            if (match_q + 8'd1 == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (data_i != '0) begin
            exp_d   = step(data_i);
            match_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Free-run the prediction so a burst error cannot re-seed a good lock.
          exp_d = step(exp_q);
          if (data_i == exp_q) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (miss_q + 8'd1 == LOSS_C) begin
              state_d = SEARCH;
              miss_d  = '0;
              if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clear_i) begin
      err_cnt_d  = '0;
      loss_cnt_d = '0;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus randomized traffic
// compared beat-by-beat against a behavioural model of the lock/error rules.
module tb_prbs_checker;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        clear = 1'b0;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic [7:0]  loss_cnt;

  int n_chk = 0;
  int n_err = 0;

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clear_i(clear),
    .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .loss_cnt_o(loss_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=searching, 1=tracking, 2=locked.
  int          m_mode, m_run, m_miss, m_errcnt, m_loss;
  logic [15:0] m_pred;
  bit          m_err;
  logic [15:0] g;

  function automatic logic [15:0] lfsr_next(input logic [15:0] c);
    int fb;
    fb = (c & 1) + ((c >> 1) & 1) + ((c >> 3) & 1) + ((c >> 12) & 1);
    return 16'((int'(c) >> 1) + (fb % 2) * 32768);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_miss = 0; m_errcnt = 0; m_loss = 0; m_pred = '0; m_err = 0;
  endtask

  task automatic model_beat(input bit v, input logic [15:0] d, input bit clr);
    m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = lfsr_next(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_pred = lfsr_next(m_pred);
          m_run++;
          if (m_run >= LOCK_CNT) begin m_mode = 2; m_miss = 0; end
        end else if (d != 0) begin
          m_pred = lfsr_next(d); m_run = 0;
        end else m_mode = 0;
      end else begin
        if (d == m_pred) m_miss = 0;
        else begin
          m_err = 1;
          m_errcnt = (m_errcnt < 65535) ? m_errcnt + 1 : 65535;
          m_miss++;
          if (m_miss >= LOSS_CNT) begin
            m_mode = 0; m_miss = 0;
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
          end
        end
        m_pred = lfsr_next(m_pred);
      end
    end
    if (clr) begin m_errcnt = 0; m_loss = 0; end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"}, 32'(locked), 32'(m_mode == 2));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errcnt));
    check({tag, ".loss_cnt"}, 32'(loss_cnt), 32'(m_loss));
  endtask

  // Drive one cycle, let the edge happen, update the model, compare 1ns later.
  task automatic beat(input bit v, input logic [15:0] d, input bit clr, input string tag);
    valid = v; data = d; clear = clr;
    @(posedge clk);
    model_beat(v, d, clr);
    #1;
    check_model(tag);
  endtask

  task automatic gen_beat(input logic [15:0] mask, input string tag);
    beat(1'b1, g ^ mask, 1'b0, tag);
    g = lfsr_next(g);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (3) beat(1'b0, 16'h1234, 1'b0, "idle");
    check("reset.locked", 32'(locked), 0);
    check("reset.err_cnt", 32'(err_cnt), 0);

    // Acquisition from the documented seed sequence.
    g = 16'hCAFE;
    check("gen.2nd", 32'(lfsr_next(16'hCAFE)), 32'h657F);
    for (int i = 0; i < 5; i++) begin
      gen_beat(16'h0, "acq");
      if (i == 3) check("acq.not_yet", 32'(locked), 0);
    end
    check("acq.locked", 32'(locked), 1);
    check("acq.err_cnt", 32'(err_cnt), 0);

    // Single-bit error while locked.
    gen_beat(16'h0001, "single");
    check("single.err", 32'(err), 1);
    check("single.cnt", 32'(err_cnt), 1);
    check("single.locked", 32'(locked), 1);
    for (int i = 0; i < 4; i++) gen_beat(16'h0, "resume");
    check("resume.err_cnt", 32'(err_cnt), 1);

    // Loss of lock after three consecutive errors, then relock.
    beat(1'b0, 16'h0, 1'b1, "clr");
    check("clr.err_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 3; i++) gen_beat(16'h8000, "loss");
    check("loss.err_cnt", 32'(err_cnt), 3);
    check("loss.loss_cnt", 32'(loss_cnt), 1);
    check("loss.locked", 32'(locked), 0);
    for (int i = 0; i < 1 + LOCK_CNT; i++) begin
      gen_beat(16'h0, "relock");
      if (i == LOCK_CNT - 1) check("relock.early", 32'(locked), 0);
    end
    check("relock.locked", 32'(locked), 1);

    // Zero words in SEARCH are ignored; gaps while locked are harmless.
    do_reset();
    repeat (4) beat(1'b1, 16'h0000, 1'b0, "zero");
    g = 16'h1D2C;
    for (int i = 0; i < 1 + LOCK_CNT; i++) gen_beat(16'h0, "zacq");
    check("zero.locked", 32'(locked), 1);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) beat(1'b0, 16'($urandom), 1'b0, "gap");
      else gen_beat(16'h0, "gapdata");
    end
    check("gap.err_cnt", 32'(err_cnt), 0);
    check("gap.loss_cnt", 32'(loss_cnt), 0);
    check("gap.locked", 32'(locked), 1);

    // Clear on the same edge as a locked mismatch.
    gen_beat(16'h0010, "pre");
    beat(1'b1, g ^ 16'h0100, 1'b1, "clrerr");
    g = lfsr_next(g);
    check("clrerr.cnt", 32'(err_cnt), 0);
    check("clrerr.err", 32'(err), 1);

    // Asynchronous reset while locked.
    gen_beat(16'h0, "prerst");
    gen_beat(16'h0004, "prerst2");
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("asyncrst");
    check("asyncrst.locked", 32'(locked), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    g = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [15:0] mask;
      r = $urandom_range(0, 99);
      mask = ($urandom_range(0, 9) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      if (r < 20) beat(1'b0, 16'($urandom), ($urandom_range(0, 40) == 0), "rnd.idle");
      else if (r < 23) beat(1'b1, 16'h0, 1'b0, "rnd.zero");
      else if (r < 25) beat(1'b1, 16'($urandom), 1'b0, "rnd.junk");
      else if (r < 27) begin
        for (int k = 0; k < LOSS_CNT; k++) gen_beat(16'h0101, "rnd.burst");
      end else gen_beat(mask, "rnd.data");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
